tern_matvec_stream: RTL
=======================

Name: tern_matvec_stream

Overview:
- Streaming, time-multiplexed ternary matrix-vector engine: y[r] = sum_j W[r][j]*x[j], W in {-1,0,+1}, x signed ACT_W-bit.
- Parametrised successor to the fully-parallel vector ternary multiplier; consumes LANES weights per cycle instead of a whole matrix.
- Activation vector is loaded once into an internal buffer, weights stream row-major and one signed result per row is emitted.
- Sits between the activation quantiser and the layer output/requant stage of a BitNet-1.58 layer.

Parameters:
- VEC_LEN, 4096: activation vector length; must be a multiple of LANES.
- NUM_ROWS, 4096: output rows per run.
- LANES, 16: ternary MACs per cycle.
- ACT_W, 8: activation width, signed.
- ACC_W, 20: accumulator/result width, signed; must be >= ACT_W+clog2(VEC_LEN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a run when FSM is IDLE; ignored otherwise.
- act_valid  in  1  activation beat valid.
- act_ready  out  1  high only in LOAD.
- act_data  in  LANES*ACT_W  LANES signed activations; lane 0 in the LSBs maps to the lowest index.
- w_valid  in  1  weight beat valid.
- w_ready  out  1  weight beat accepted when w_valid&&w_ready.
- w_data  in  LANES*2  ternary codes; lane 0 in the LSBs.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_data  out  ACC_W  signed row result.
- out_row  out  clog2(NUM_ROWS)  row index of out_data.
- busy  out  1  FSM not IDLE or output pending.
- done  out  1  single-cycle pulse when the last row result is accepted.
- err  out  1  sticky; reserved weight code seen; cleared by start.

Behaviour:
- Weight codes: 2'b00=0, 2'b01=+1, 2'b11=-1, 2'b10=reserved. The reserved code contributes 0 and sets err.
- Reset (rst low, async): FSM=IDLE; all outputs 0; buffer index, beat counter, row counter and accumulator are 0. Activation buffer contents are don't-care. Reset mid-run aborts with no done pulse.
- FSM IDLE -> LOAD on start.
- LOAD: accept VEC_LEN/LANES beats into buffer words 0..N-1 in order. After the last beat -> COMPUTE.
- COMPUTE, per accepted weight beat k within a row:
  - lane_sum = signed sum over lanes of (+x, -x or 0), with x = buffer word k.
  - acc <= (k==0 ? 0 : acc) + sign-extended lane_sum.
- On the final beat of a row: out_data <= acc+lane_sum, out_row <= row, out_valid <= 1 on the next cycle. Latency is 1 cycle from the last weight beat to out_valid.
- Single-entry output register:
  - w_ready = (state==COMPUTE) && !(last beat of row pending && out_valid && !out_ready).
  - Non-final beats are never stalled by the output.
  - A final beat is accepted in the same cycle the old result is accepted.
- out_valid holds and out_data/out_row stay stable until out_ready.
- After the final beat of row NUM_ROWS-1 -> DRAIN. DRAIN -> IDLE when that result is accepted; done pulses in that cycle.
- Arithmetic wraps modulo 2^ACC_W unless the optional feature is enabled.
- start outside IDLE is ignored. act_valid outside LOAD and w_valid outside COMPUTE are ignored (ready is low).

Optional Feature:
- TERN_MATVEC_SAT_EN defined: the accumulator update saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1], and a sticky sat_flag output (1 bit, cleared by start) marks the first clip.
- Undefined: two's-complement wrap, and no sat_flag port.

Decomposition:
- Package tern_pkg:
  - weight code localparams TERN_ZERO, TERN_POS, TERN_NEG, TERN_RSVD.
  - typedef of the FSM state enum {IDLE, LOAD, COMPUTE, DRAIN}.
  - clog2-based width helper function.
- Sub-module tern_lane_sum: combinational LANES-wide ternary select plus balanced adder tree. Outputs a signed ACT_W+clog2(LANES)+1 sum and a per-beat reserved-code flag.

Test Plan (VEC_LEN=16, LANES=4, NUM_ROWS=4, ACT_W=8, ACC_W=12):
- x[j]=j-8, W=identity -> out_data rows 0..3 = -8,-7,-6,-5 with out_row 0..3; done pulses once.
- x all 127, W all 2'b11 -> every row = -2032; all +1 with x=-128 -> -2048.
- Random x/W, out_ready toggling 1-of-3 cycles -> results match the golden model in order; w_ready drops only on final beats while the output is held, and nothing is lost or duplicated.
- One lane code 2'b10 in row 2 -> err=1 and stays set; that lane counts as 0; err clears on the next start.
- ACC_W=10, x all 127, W all +1 -> sum 2032: with TERN_MATVEC_SAT_EN, out_data=511 and sat_flag=1; without it, wrapped value -16.
- rst low during COMPUTE row 1 -> outputs 0 asynchronously and FSM IDLE, with no done pulse. A fresh start then reproduces the identity results.

Source files
------------

// File: rtl/tern_matvec_stream_pkg.sv
// ---------------------------------------------------------------------------
// tern_pkg: shared definitions for the streaming ternary matrix-vector engine.
//   - TERN_* : 2-bit weight encodings (00=0, 01=+1, 11=-1, 10=reserved)
//   - tern_state_e : engine FSM states
//   - tern_width() : clog2-style width helper that never returns 0
// ---------------------------------------------------------------------------
package tern_pkg;

  localparam logic [1:0] TERN_ZERO = 2'b00;
  localparam logic [1:0] TERN_POS  = 2'b01;
  localparam logic [1:0] TERN_NEG  = 2'b11;
  localparam logic [1:0] TERN_RSVD = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } tern_state_e;

  // Index width for a range of n entries; a 1-entry range still needs 1 bit.
  function automatic int tern_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tern_matvec_stream_if.sv
// ---------------------------------------------------------------------------
// tern_matvec_stream_if: handshake/bus bundle of the ternary mat-vec engine.
//   slave  modport : engine side (receives start/activations/weights).
//   master modport : producer/consumer side.
//   Optional sat_flag signal exists only when TERN_MATVEC_SAT_EN is defined.
// ---------------------------------------------------------------------------
interface tern_matvec_stream_if #(
  parameter int LANES = 16,
  parameter int ACT_W = 8,
  parameter int ACC_W = 20,
  parameter int ROW_W = 12
) ();
  logic                     start;
  logic                     act_valid;
  logic                     act_ready;
  logic [LANES*ACT_W-1:0]   act_data;
  logic                     w_valid;
  logic                     w_ready;
  logic [LANES*2-1:0]       w_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic [ROW_W-1:0]         out_row;
  logic                     busy;
  logic                     done;
  logic                     err;
`ifdef TERN_MATVEC_SAT_EN
  logic                     sat_flag;
`endif

  modport slave (
`ifdef TERN_MATVEC_SAT_EN
    output sat_flag,
`endif
    input  start, act_valid, act_data, w_valid, w_data, out_ready,
    output act_ready, w_ready, out_valid, out_data, out_row, busy, done, err
  );

  modport master (
`ifdef TERN_MATVEC_SAT_EN
    input  sat_flag,
`endif
    output start, act_valid, act_data, w_valid, w_data, out_ready,
    input  act_ready, w_ready, out_valid, out_data, out_row, busy, done, err
  );
endinterface

// File: rtl/tern_matvec_stream_lane_sum.sv
// ---------------------------------------------------------------------------
// tern_lane_sum: combinational LANES-wide ternary select + balanced adder tree.
//   act_i  : LANES signed activations, lane 0 in the LSBs
//   w_i    : LANES 2-bit ternary codes, lane 0 in the LSBs
//   sum_o  : signed sum of (+x, -x, 0) over lanes
//   rsvd_o : some lane carried the reserved code (that lane contributes 0)
// ---------------------------------------------------------------------------
module tern_lane_sum
  import tern_pkg::*;
#(
  parameter int LANES = 16,
  parameter int ACT_W = 8,
  parameter int SUM_W = ACT_W + $clog2(LANES) + 1
) (
  input  logic [LANES*ACT_W-1:0]  act_i,
  input  logic [LANES*2-1:0]      w_i,
  output logic signed [SUM_W-1:0] sum_o,
  output logic                    rsvd_o
);
  // Tree padded to a power of two; heap layout, leaves at LEAVES..2*LEAVES-1.
  localparam int LEAVES = 1 << tern_width(LANES);

  logic signed [SUM_W-1:0] node_s [1:2*LEAVES-1];
  logic signed [SUM_W-1:0] x_s;

  // Per-lane ternary select, then pairwise reduction toward the root.
  always_comb begin
    rsvd_o = 1'b0;
    x_s    = '0;
    for (int n = 1; n < 2*LEAVES; n++) node_s[n] = '0;
    for (int l = 0; l < LANES; l++) begin
      x_s = {{(SUM_W-ACT_W){act_i[l*ACT_W+ACT_W-1]}}, act_i[l*ACT_W +: ACT_W]};
      case (w_i[2*l +: 2])
        TERN_ZERO: node_s[LEAVES+l] = '0;
        TERN_POS:  node_s[LEAVES+l] = x_s;
        TERN_NEG:  node_s[LEAVES+l] = -x_s;
        TERN_RSVD: begin
          node_s[LEAVES+l] = '0;
          rsvd_o           = 1'b1;
        end
        default:   node_s[LEAVES+l] = '0;
      endcase
    end
    for (int n = LEAVES-1; n >= 1; n--) node_s[n] = node_s[2*n] + node_s[2*n+1];
    sum_o = node_s[1];
  end
endmodule

// File: rtl/tern_matvec_stream.sv
// ---------------------------------------------------------------------------
// tern_matvec_stream: streaming ternary matrix-vector engine, y[r]=sum W[r][j]*x[j].
// Activations are loaded once (VEC_LEN/LANES beats), weights stream row-major
// LANES codes per beat, one signed result per row leaves a 1-entry output reg.
//   clk, rst (async, active low), bus (tern_matvec_stream_if.slave):
//   start, act_*, w_*, out_*, busy, done, err [, sat_flag].
// Build option: TERN_MATVEC_SAT_EN -> saturating accumulator + sat_flag,
// otherwise two's-complement wrap.
// ---------------------------------------------------------------------------
module tern_matvec_stream
  import tern_pkg::*;
#(
  parameter int VEC_LEN  = 4096,
  parameter int NUM_ROWS = 4096,
  parameter int LANES    = 16,
  parameter int ACT_W    = 8,
  parameter int ACC_W    = 20
) (
  input  logic clk,
  input  logic rst,
  tern_matvec_stream_if.slave bus
);
  localparam int NBEATS = VEC_LEN / LANES;
  localparam int BEAT_W = tern_width(NBEATS);
  localparam int ROW_W  = tern_width(NUM_ROWS);
  localparam int SUM_W  = ACT_W + $clog2(LANES) + 1;
  // Headroom so neither operand is truncated before wrap/clip.
  localparam int EXT_W  = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(NUM_ROWS - 1);
`ifdef TERN_MATVEC_SAT_EN
  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
  logic clip_s;
  logic sat_q;
`endif

  tern_state_e             state_q;
  logic [LANES*ACT_W-1:0]  act_buf_q [NBEATS];
  logic [BEAT_W-1:0]       buf_idx_q, beat_q;
  logic [ROW_W-1:0]        row_q, out_row_q;
  logic signed [ACC_W-1:0] acc_q, acc_d, out_data_q;
  logic                    out_valid_q, err_q;
  logic signed [SUM_W-1:0] lane_sum_s;
  logic signed [EXT_W-1:0] base_s, ext_sum_s;
  logic rsvd_s, last_beat_s, act_fire_s, w_ready_s, w_fire_s, out_fire_s;

  tern_lane_sum #(.LANES(LANES), .ACT_W(ACT_W), .SUM_W(SUM_W)) u_lane_sum (
    .act_i  (act_buf_q[beat_q]),
    .w_i    (bus.w_data),
    .sum_o  (lane_sum_s),
    .rsvd_o (rsvd_s)
  );

  assign last_beat_s = (beat_q == LAST_BEAT);
  assign act_fire_s  = (state_q == LOAD) && bus.act_valid;
  // A final beat may only land if the output slot is empty or emptying now.
  assign w_ready_s   = (state_q == COMPUTE) && !(last_beat_s && out_valid_q && !bus.out_ready);
  assign w_fire_s    = w_ready_s && bus.w_valid;
  assign out_fire_s  = out_valid_q && bus.out_ready;

  assign bus.act_ready = (state_q == LOAD);
  assign bus.w_ready   = w_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_row   = out_row_q;
  assign bus.busy      = (state_q != IDLE) || out_valid_q;
  assign bus.done      = (state_q == DRAIN) && out_fire_s;
  assign bus.err       = err_q;
`ifdef TERN_MATVEC_SAT_EN
  assign bus.sat_flag  = sat_q;
`endif

  // Accumulator next value: restart at beat 0, then wrap or clip to ACC_W.
  always_comb begin
    base_s    = (beat_q == '0) ? '0 : {{(EXT_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    ext_sum_s = base_s + {{(EXT_W-SUM_W){lane_sum_s[SUM_W-1]}}, lane_sum_s};
`ifdef TERN_MATVEC_SAT_EN
    if (ext_sum_s > SAT_MAX) begin
      acc_d  = ACC_W'(SAT_MAX);
      clip_s = 1'b1;
    end else if (ext_sum_s < SAT_MIN) begin
      acc_d  = ACC_W'(SAT_MIN);
      clip_s = 1'b1;
    end else begin
      acc_d  = ACC_W'(ext_sum_s);
      clip_s = 1'b0;
    end
`else
    acc_d = ACC_W'(ext_sum_s);
`endif
  end

  // Activation buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (act_fire_s) act_buf_q[buf_idx_q] <= bus.act_data;
  end

  // Control FSM, counters, accumulator, sticky flags and output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      buf_idx_q   <= '0;
      beat_q      <= '0;
      row_q       <= '0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
`ifdef TERN_MATVEC_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          state_q   <= LOAD;
          buf_idx_q <= '0;
          err_q     <= 1'b0;
`ifdef TERN_MATVEC_SAT_EN
          sat_q     <= 1'b0;
`endif
        end
        LOAD: if (act_fire_s) begin
          if (buf_idx_q == LAST_BEAT) begin
            state_q   <= COMPUTE;
            buf_idx_q <= '0;
            beat_q    <= '0;
            row_q     <= '0;
          end else begin
            buf_idx_q <= buf_idx_q + BEAT_W'(1);
          end
        end
        COMPUTE: if (w_fire_s) begin
          acc_q <= acc_d;
          if (rsvd_s) err_q <= 1'b1;
`ifdef TERN_MATVEC_SAT_EN
          if (clip_s) sat_q <= 1'b1;
`endif
          if (last_beat_s) begin
            beat_q <= '0;
            if (row_q == LAST_ROW) begin
              state_q <= DRAIN;
              row_q   <= '0;
            end else begin
              row_q <= row_q + ROW_W'(1);
            end
          end else begin
            beat_q <= beat_q + BEAT_W'(1);
          end
        end
        DRAIN: if (out_fire_s) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (w_fire_s && last_beat_s) begin
        out_valid_q <= 1'b1;
        out_data_q  <= acc_d;
        out_row_q   <= row_q;
      end else if (out_fire_s) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule
